// File: rtl/cmos_capture_rgb888_if.sv
// Sensor-side DVP bus plus the captured-pixel stream of cmos_capture_rgb888.
// The master modport drives the sensor lines; the slave modport is the capture block.
interface cmos_capture_if;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        capture_en;
  logic [23:0] rgb_out;
  logic        rgb_valid;
  logic        frame_start;
  logic        frame_done;
  logic [9:0]  x_cnt;
  logic [8:0]  y_cnt;
  logic        frame_err;

  modport master (
    output cmos_vsync, cmos_href, cmos_data, capture_en,
    input  rgb_out, rgb_valid, frame_start, frame_done, x_cnt, y_cnt, frame_err
  );

  modport slave (
    input  cmos_vsync, cmos_href, cmos_data, capture_en,
    output rgb_out, rgb_valid, frame_start, frame_done, x_cnt, y_cnt, frame_err
  );
endinterface

// File: rtl/cmos_capture_rgb888.sv
// DVP RGB565 capture: ignores the first frames after reset, pairs bytes into
// RGB888 pixels and tracks line/frame geometry with a sticky per-frame error.
module cmos_capture_rgb888 #(
  parameter int FRAME_SKIP = 10,
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480
) (
  input logic           clk,
  input logic           rst,
  cmos_capture_if.slave bus
);

  typedef enum logic [1:0] {SKIP, WAIT_VS, CAPTURE} state_t;

  localparam logic [15:0] SKIP_N = 16'(FRAME_SKIP);
  localparam logic [10:0] H_N    = 11'(H_PIXELS);
  localparam logic [9:0]  V_N    = 10'(V_LINES);

  function automatic logic [23:0] expand565(input logic [15:0] px);
    return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  state_t      state, state_nxt;
  logic [15:0] skip_cnt;

  logic        vsync_p0, href_p0;
  logic [7:0]  data_p0;
  logic        vsync_p1, href_p1;
  logic        vs_rise, href_fall, in_cap;

  logic        phase_p1;
  logic [7:0]  hi_p1;
  logic        emit;

  logic [23:0] rgb_p2;
  logic        vld_p2, start_p2, done_p2, err_p2;
  logic [9:0]  x_p2;
  logic [8:0]  y_p2;
  logic        frame_px;
  logic [10:0] line_px;

  // Stage p0/p1: input registers and their delayed copies for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_p0 <= 1'b0;
      href_p0  <= 1'b0;
      data_p0  <= 8'd0;
      vsync_p1 <= 1'b0;
      href_p1  <= 1'b0;
    end else begin
      vsync_p0 <= bus.cmos_vsync;
      href_p0  <= bus.cmos_href;
      data_p0  <= bus.cmos_data;
      vsync_p1 <= vsync_p0;
      href_p1  <= href_p0;
    end
  end

  assign vs_rise   = vsync_p0 & ~vsync_p1;
  assign href_fall = ~href_p0 & href_p1;
  assign in_cap    = (state == CAPTURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SKIP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SKIP:    if (skip_cnt >= SKIP_N) state_nxt = WAIT_VS;
      WAIT_VS: if (vs_rise && bus.capture_en) state_nxt = CAPTURE;
      CAPTURE: if (vs_rise && !bus.capture_en) state_nxt = WAIT_VS;
      default: state_nxt = SKIP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) skip_cnt <= 16'd0;
    else if (state == SKIP && vs_rise && skip_cnt < SKIP_N) skip_cnt <= skip_cnt + 16'd1;
  end

  // Byte pairing; a vsync edge wins over href and drops any half pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_p1 <= 1'b0;
    else if (!in_cap || !href_p0 || vs_rise) phase_p1 <= 1'b0;
    else phase_p1 <= ~phase_p1;
  end

  always_ff @(posedge clk) begin
    if (in_cap && href_p0 && !phase_p1) hi_p1 <= data_p0;
  end

  assign emit    = in_cap && href_p0 && phase_p1 && !vs_rise;
  assign line_px = {1'b0, x_p2} + {10'd0, vld_p2};

  // Stage p2: registered pixel, strobes, counters and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_p2   <= 24'd0;
      vld_p2   <= 1'b0;
      start_p2 <= 1'b0;
      done_p2  <= 1'b0;
      err_p2   <= 1'b0;
      x_p2     <= 10'd0;
      y_p2     <= 9'd0;
      frame_px <= 1'b0;
    end else begin
      vld_p2   <= emit;
      start_p2 <= emit && !frame_px;
      done_p2  <= vs_rise && in_cap && frame_px;
      if (emit) rgb_p2 <= expand565({hi_p1, data_p0});

      if (vs_rise) begin
        x_p2     <= 10'd0;
        y_p2     <= 9'd0;
        frame_px <= 1'b0;
      end else begin
        if (emit) frame_px <= 1'b1;
        // line_px includes a strobe landing in the same cycle as the href edge
        if (in_cap && href_fall) begin
          x_p2 <= 10'd0;
          if (line_px != 11'd0) y_p2 <= sat_inc9(y_p2);
        end else if (vld_p2) begin
          x_p2 <= sat_inc10(x_p2);
        end
      end

      if (emit && !frame_px) begin
        err_p2 <= 1'b0;
      end else if (in_cap && vs_rise) begin
        if (frame_px && ({1'b0, y_p2} != V_N)) err_p2 <= 1'b1;
      end else if (in_cap && href_fall) begin
        if (phase_p1 || (line_px != H_N)) err_p2 <= 1'b1;
      end
    end
  end

  assign bus.rgb_out     = rgb_p2;
  assign bus.rgb_valid   = vld_p2;
  assign bus.frame_start = start_p2;
  assign bus.frame_done  = done_p2;
  assign bus.x_cnt       = x_p2;
  assign bus.y_cnt       = y_p2;
  assign bus.frame_err   = err_p2;

endmodule

// File: tb/tb_cmos_capture_rgb888.sv
// Bench for cmos_capture_rgb888: drives DVP frames and compares every pixel
// strobe, counter and flag against an arithmetic model of the capture rules.
module tb_cmos_capture_rgb888;
  localparam int F_SKIP = 2;
  localparam int H_PX   = 4;
  localparam int V_LN   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  cmos_capture_if bus();

  cmos_capture_rgb888 #(.FRAME_SKIP(F_SKIP), .H_PIXELS(H_PX), .V_LINES(V_LN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] v; logic [23:0] rgb; } px_t;
  typedef struct { logic [23:0] rgb; int x; int y; int cyc; bit first; } exp_t;
  typedef struct { logic [7:0] hi; logic [7:0] lo; logic [23:0] rgb; } vec_t;

  px_t   src[$];
  exp_t  expq[$];
  vec_t  vecs[8];

  int          vs_n = 0;
  bit          cap = 1'b0;
  bit          frame_px = 1'b0;
  int          lines_px = 0;
  bit          cur_err = 1'b0;
  int          exp_done = 0;
  int          done_cnt = 0;
  logic [23:0] last_rgb = 24'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  function automatic logic [23:0] model_rgb(input logic [15:0] v);
    int r, g, b;
    r = int'(v) / 2048;
    g = (int'(v) / 32) % 64;
    b = int'(v) % 32;
    return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
  endfunction

  task automatic monitor();
    exp_t e;
    if (rst) return;
    if (bus.frame_done) done_cnt++;
    if (bus.rgb_valid || bus.frame_start) begin
      if (expq.size() == 0) begin
        chk("spurious_strobe", 32'({bus.frame_start, bus.rgb_valid}), 32'd0);
      end else begin
        e = expq.pop_front();
        chk("rgb_valid", 32'(bus.rgb_valid), 32'd1);
        chk("rgb_out", 32'(bus.rgb_out), 32'(e.rgb));
        chk("x_cnt", 32'(bus.x_cnt), e.x);
        chk("y_cnt", 32'(bus.y_cnt), e.y);
        chk("strobe_cycle", cyc, e.cyc);
        chk("frame_start", 32'(bus.frame_start), 32'(e.first));
        if (bus.frame_start) chk("frame_err_at_start", 32'(bus.frame_err), 32'd0);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int npix, input bit odd);
    px_t  p;
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      if (src.size() > 0) p = src.pop_front();
      else begin
        p.v   = 16'($urandom);
        p.rgb = model_rgb(p.v);
      end
      bus.cmos_href = 1'b1;
      bus.cmos_data = p.v[15:8];
      step();
      bus.cmos_data = p.v[7:0];
      if (cap) begin
        e.rgb   = p.rgb;
        e.x     = i;
        e.y     = lines_px;
        e.cyc   = cyc + 2;
        e.first = !frame_px && (i == 0);
        expq.push_back(e);
        last_rgb = p.rgb;
      end
      step();
    end
    if (odd) begin
      bus.cmos_data = 8'($urandom);
      step();
    end
    bus.cmos_href = 1'b0;
    bus.cmos_data = 8'($urandom);
    repeat (5) step();
    if (cap) begin
      if (npix > 0) begin
        frame_px = 1'b1;
        lines_px++;
      end
      if (odd || npix != H_PX) cur_err = 1'b1;
      if (frame_px) chk("frame_err_after_line", 32'(bus.frame_err), 32'(cur_err));
    end
  endtask

  // Ends the frame in progress and opens the next one.
  task automatic do_vsync();
    bit ended;
    chk("rgb_out_hold", 32'(bus.rgb_out), 32'(last_rgb));
    ended = cap && frame_px;
    if (ended) begin
      exp_done++;
      if (lines_px != V_LN) cur_err = 1'b1;
    end
    vs_n++;
    cap = (vs_n > F_SKIP) && (bus.capture_en == 1'b1);
    bus.cmos_vsync = 1'b1;
    repeat (3) step();
    bus.cmos_vsync = 1'b0;
    repeat (4) step();
    chk("frame_done_count", done_cnt, exp_done);
    chk("strobes_pending", expq.size(), 0);
    if (ended) chk("frame_err_at_end", 32'(bus.frame_err), 32'(cur_err));
    frame_px = 1'b0;
    lines_px = 0;
    cur_err  = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rgb_out"}, 32'(bus.rgb_out), 32'd0);
    chk({tag, "_rgb_valid"}, 32'(bus.rgb_valid), 32'd0);
    chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_x_cnt"}, 32'(bus.x_cnt), 32'd0);
    chk({tag, "_y_cnt"}, 32'(bus.y_cnt), 32'd0);
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hF8, 8'h00, 24'hFF0000};
    vecs[1] = '{8'h07, 8'hE0, 24'h00FF00};
    vecs[2] = '{8'h00, 8'h1F, 24'h0000FF};
    vecs[3] = '{8'h84, 8'h10, 24'h848284};
    vecs[4] = '{8'hFF, 8'hFF, 24'hFFFFFF};
    vecs[5] = '{8'h00, 8'h00, 24'h000000};
    vecs[6] = '{8'h08, 8'h21, 24'h080408};
    vecs[7] = '{8'h7B, 8'hEF, 24'h7B7D7B};

    bus.cmos_vsync = 1'b0;
    bus.cmos_href  = 1'b0;
    bus.cmos_data  = 8'd0;
    bus.capture_en = 1'b1;
    rst = 1'b1;
    step();
    step();
    chk_zero_outputs("reset");
    rst = 1'b0;
    step();
    step();

    // Two skipped frames, then a captured frame carrying the colour table
    repeat (2) begin
      do_vsync();
      send_line(H_PX, 1'b0);
      send_line(H_PX, 1'b0);
    end
    do_vsync();
    for (int i = 0; i < 8; i++)
      src.push_back('{v: {vecs[i].hi, vecs[i].lo}, rgb: vecs[i].rgb});
    send_line(H_PX, 1'b0);
    send_line(H_PX, 1'b0);

    repeat (2) begin
      do_vsync();
      send_line(H_PX, 1'b0);
      send_line(H_PX, 1'b0);
    end

    // Odd byte count, over-long line and short frame, each followed by a clean frame
    do_vsync();
    send_line(1, 1'b1);
    send_line(H_PX, 1'b0);
    do_vsync();
    send_line(H_PX, 1'b0);
    send_line(H_PX, 1'b0);
    do_vsync();
    send_line(5, 1'b0);
    send_line(H_PX, 1'b0);
    do_vsync();
    send_line(H_PX, 1'b0);
    send_line(H_PX, 1'b0);
    do_vsync();
    send_line(H_PX, 1'b0);
    do_vsync();
    send_line(H_PX, 1'b0);
    send_line(H_PX, 1'b0);

    // capture_en dropped mid-frame, then restored during an idle frame
    do_vsync();
    send_line(H_PX, 1'b0);
    bus.capture_en = 1'b0;
    send_line(H_PX, 1'b0);
    do_vsync();
    send_line(H_PX, 1'b0);
    send_line(H_PX, 1'b0);
    bus.capture_en = 1'b1;
    do_vsync();
    send_line(H_PX, 1'b0);

    // Reset in the middle of the second line
    bus.cmos_href = 1'b1;
    bus.cmos_data = 8'hF8;
    step();
    bus.cmos_data = 8'h00;
    step();
    bus.cmos_data = 8'h12;
    step();
    rst = 1'b1;
    #1;
    chk_zero_outputs("midline_reset");
    vs_n = 0;
    cap = 1'b0;
    frame_px = 1'b0;
    lines_px = 0;
    cur_err = 1'b0;
    last_rgb = 24'd0;
    expq.delete();
    src.delete();
    bus.cmos_href = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    repeat (3) begin
      do_vsync();
      send_line(H_PX, 1'b0);
      send_line(H_PX, 1'b0);
    end
    do_vsync();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
